// File: rtl/pipe_stage_chain.sv
// Generic in-order register chain with per-stage stall/flush and debug counters.
// Latency: STAGES edges from in_valid sampled to out_valid; one payload per cycle when unblocked.
// Backpressure: out_ready and stall ripple back combinationally to in_ready; blocked stages hold.
module pipe_stage_chain #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4,
    parameter int CNT_W  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    input  logic [STAGES-1:0]           stall,
    input  logic [STAGES-1:0]           flush,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        out_ready,
    output logic [STAGES-1:0]           stage_valid,
    output logic [STAGES*WIDTH-1:0]     stage_data,
    output logic [$clog2(STAGES+1)-1:0] occupancy,
    output logic [CNT_W-1:0]            retired_cnt,
    output logic [CNT_W-1:0]            flushed_cnt
);

    localparam int OCC_W = $clog2(STAGES+1);

    logic [STAGES-1:0]             v;
    logic [STAGES-1:0][WIDTH-1:0]  d;
    logic [STAGES-1:0]             ve;
    logic [STAGES-1:0]             move;
    logic [STAGES-1:0]             accept;
    logic [STAGES:0]               acc_ext;
    logic [STAGES-1:0]             src_v;
    logic [STAGES-1:0][WIDTH-1:0]  src_d;
    logic [OCC_W-1:0]              occ_pop;
    logic [OCC_W-1:0]              flush_pop;
    logic                          xfer;
    logic [CNT_W:0]                ret_sum;
    logic [CNT_W:0]                fl_sum;

    assign ve = v & ~flush;

    // Ready ripples from the output back to stage 0, so walk oldest to youngest.
    always_comb begin
        acc_ext         = '0;
        move            = '0;
        acc_ext[STAGES] = out_ready;
        for (int k = STAGES-1; k >= 0; k--) begin
            move[k]    = ve[k] & ~stall[k] & acc_ext[k+1];
            acc_ext[k] = ~stall[k] & (~ve[k] | move[k]);
        end
    end

    assign accept = acc_ext[STAGES-1:0];

    // Source of each stage's load: upstream port for stage 0, predecessor otherwise.
    for (genvar k = 0; k < STAGES; k++) begin : g_src
        if (k == 0) begin : g_head
            assign src_v[k] = in_valid;
            assign src_d[k] = in_data;
        end else begin : g_link
            assign src_v[k] = move[k-1];
            assign src_d[k] = d[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            v <= '0;
            d <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (accept[k]) begin
                    v[k] <= src_v[k];
                    d[k] <= src_d[k];
                end else begin
                    v[k] <= ve[k];
                end
            end
        end
    end

    always_comb begin
        occ_pop   = '0;
        flush_pop = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_pop   = occ_pop + OCC_W'(v[k]);
            flush_pop = flush_pop + OCC_W'(v[k] & flush[k]);
        end
    end

    assign xfer    = out_valid & out_ready;
    assign ret_sum = {1'b0, retired_cnt} + (CNT_W+1)'(xfer);
    assign fl_sum  = {1'b0, flushed_cnt} + (CNT_W+1)'(flush_pop);

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            retired_cnt <= '0;
            flushed_cnt <= '0;
        end else begin
            retired_cnt <= ret_sum[CNT_W] ? '1 : ret_sum[CNT_W-1:0];
            flushed_cnt <= fl_sum[CNT_W]  ? '1 : fl_sum[CNT_W-1:0];
        end
    end

    assign in_ready    = accept[0];
    assign out_valid   = ve[STAGES-1] & ~stall[STAGES-1];
    assign out_data    = d[STAGES-1];
    assign stage_valid = ve;
    assign stage_data  = d;
    assign occupancy   = occ_pop;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed scenarios plus a randomized run against a slot-level model and a payload scoreboard.
module tb_pipe_stage_chain;

    localparam int W   = 16;
    localparam int S   = 4;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic [W-1:0]       in_data = '0;
    logic               in_ready;
    logic [S-1:0]       stall = '0;
    logic [S-1:0]       flush = '0;
    logic               out_valid;
    logic [W-1:0]       out_data;
    logic               out_ready = 1'b0;
    logic [S-1:0]       stage_valid;
    logic [S*W-1:0]     stage_data;
    logic [2:0]         occupancy;
    logic [CW-1:0]      retired_cnt;
    logic [CW-1:0]      flushed_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: one slot per stage, plus queue of live payloads in program order.
    bit           m_v[S];
    logic [W-1:0] m_d[S];
    bit           alive[S];
    bit           leaves[S];
    bit           takes[S];
    int           m_ret = 0;
    int           m_fl = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] got[$];

    pipe_stage_chain #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .stall(stall), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .stage_valid(stage_valid), .stage_data(stage_data),
        .occupancy(occupancy), .retired_cnt(retired_cnt), .flushed_cnt(flushed_cnt)
    );

    always #5 clk = ~clk;

    // An entry leaves its slot when it is live, not held, and the slot ahead frees up.
    function automatic void model_eval();
        bit room = out_ready;
        for (int k = S-1; k >= 0; k--) begin
            alive[k]  = m_v[k] && !flush[k];
            leaves[k] = alive[k] && !stall[k] && room;
            takes[k]  = !stall[k] && (!alive[k] || leaves[k]);
            room      = takes[k];
        end
    endfunction

    task automatic model_commit();
        bit           nv[S];
        logic [W-1:0] nd[S];
        int           pop = 0;
        if (!reset) begin
            for (int k = 0; k < S; k++) begin
                m_v[k] = 1'b0;
                m_d[k] = '0;
            end
            m_ret = 0;
            m_fl  = 0;
            sb.delete();
        end else begin
            for (int k = 0; k < S; k++) begin
                if (m_v[k] && flush[k]) begin
                    pop++;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (sb[i] === m_d[k]) begin
                            sb.delete(i);
                            break;
                        end
                    end
                end
            end
            m_fl = (m_fl + pop > SAT) ? SAT : m_fl + pop;
            if (leaves[S-1]) begin
                if (m_ret < SAT) m_ret++;
                if (sb.size() > 0) void'(sb.pop_front());
            end
            if (takes[0] && in_valid) sb.push_back(in_data);
            for (int k = 0; k < S; k++) begin
                if (takes[k]) begin
                    if (k == 0) begin
                        nv[k] = in_valid;
                        nd[k] = in_data;
                    end else begin
                        nv[k] = leaves[k-1];
                        nd[k] = m_d[k-1];
                    end
                end else begin
                    nv[k] = alive[k];
                    nd[k] = m_d[k];
                end
            end
            for (int k = 0; k < S; k++) begin
                m_v[k] = nv[k];
                m_d[k] = nd[k];
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
        if (reset && out_valid && out_ready) got.push_back(out_data);
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b0; stall = '0; flush = '0; out_ready = 1'b0;
        settle();
        tick();
        reset = 1'b1;
        got.delete();
    endtask

    task automatic fill_four(input int base);
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = W'(base + c);
            settle();
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        checks++; if (stage_valid !== 4'b0000) begin errors++; $display("FAIL reset_stage_valid: got %b expected 0000", stage_valid); end
        checks++; if (retired_cnt !== 4'd0 || flushed_cnt !== 4'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", retired_cnt, flushed_cnt); end
        tick();
    endtask

    task automatic test_stream();
        int nout = 0;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 8);
            in_data  = W'(c + 1);
            settle();
            if (c < 8) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: cycle %0d got %b expected 1", c, in_ready); end
            end
            if (out_valid) begin
                checks++;
                if (out_data !== W'(nout + 1) || c != nout + 4) begin
                    errors++; $display("FAIL stream_out: got %h at cycle %0d expected %h at cycle %0d", out_data, c, nout + 1, nout + 4);
                end
                nout++;
            end
            tick();
        end
        settle();
        checks++; if (nout != 8) begin errors++; $display("FAIL stream_count: got %0d expected 8", nout); end
        checks++; if (retired_cnt !== 4'd8) begin errors++; $display("FAIL stream_retired: got %0d expected 8", retired_cnt); end
        checks++; if (flushed_cnt !== 4'd0) begin errors++; $display("FAIL stream_flushed: got %0d expected 0", flushed_cnt); end
        tick();
    endtask

    task automatic test_backpressure();
        int idx = 0;
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_data  = W'(10 + idx);
            settle();
            if (in_ready) idx++;
            tick();
        end
        settle();
        checks++; if (idx != 4) begin errors++; $display("FAIL bp_accepts: got %0d expected 4", idx); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_occupancy: got %0d expected 4", occupancy); end
        checks++; if (out_valid !== 1'b1 || out_data !== 16'h000A) begin errors++; $display("FAIL bp_head: got %b/%h expected 1/000a", out_valid, out_data); end
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (idx < 6);
            in_data  = W'(10 + idx);
            settle();
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (got.size() != 6) begin errors++; $display("FAIL bp_drain_count: got %0d expected 6", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== W'(10 + i)) begin errors++; $display("FAIL bp_drain_order: item %0d got %h expected %h", i, got[i], 10 + i); end
        end
        settle();
        checks++; if (retired_cnt !== 4'd6) begin errors++; $display("FAIL bp_retired: got %0d expected 6", retired_cnt); end
        tick();
    endtask

    task automatic test_stall_bubble();
        int idx = 0;
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (idx < 10);
            in_data  = W'(33 + idx);
            stall    = (c == 3 || c == 4) ? 4'b0010 : 4'b0000;
            settle();
            if (c == 3 || c == 4) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: cycle %0d got %b expected 0", c, in_ready); end
            end
            if (c == 4 || c == 5) begin
                checks++; if (stage_valid[2] !== 1'b0) begin errors++; $display("FAIL stall_bubble: cycle %0d stage2 valid %b expected 0", c, stage_valid[2]); end
            end
            if (c == 4) begin
                checks++; if (stage_valid[1] !== 1'b1 || stage_data[W +: W] !== 16'h0022) begin errors++; $display("FAIL stall_hold: got %b/%h expected 1/0022", stage_valid[1], stage_data[W +: W]); end
            end
            if (in_valid && in_ready) idx++;
            tick();
        end
        stall = '0;
        in_valid = 1'b0;
        checks++; if (got.size() != 10) begin errors++; $display("FAIL stall_count: got %0d expected 10", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== W'(33 + i)) begin errors++; $display("FAIL stall_order: item %0d got %h expected %h", i, got[i], 33 + i); end
        end
    endtask

    task automatic test_flush();
        do_reset();
        fill_four(1);
        flush = 4'b0011;
        settle();
        checks++; if (stage_valid !== 4'b1100) begin errors++; $display("FAIL flush_taps: got %b expected 1100", stage_valid); end
        tick();
        flush = '0;
        settle();
        checks++; if (stage_valid !== 4'b1100) begin errors++; $display("FAIL flush_after: got %b expected 1100", stage_valid); end
        checks++; if (flushed_cnt !== 4'd2) begin errors++; $display("FAIL flush_cnt: got %0d expected 2", flushed_cnt); end
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL flush_occupancy: got %0d expected 2", occupancy); end
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            settle();
            tick();
        end
        checks++;
        if (got.size() != 2 || got[0] !== 16'h0001 || got[1] !== 16'h0002) begin
            errors++; $display("FAIL flush_retire: got %0d items expected 0001,0002", got.size());
        end
        settle();
        checks++; if (retired_cnt !== 4'd2 || flushed_cnt !== 4'd2) begin errors++; $display("FAIL flush_counters: got %0d/%0d expected 2/2", retired_cnt, flushed_cnt); end
        tick();
    endtask

    task automatic test_flush_stall();
        do_reset();
        fill_four(1);
        stall = 4'b0010;
        flush = 4'b0010;
        settle();
        checks++; if (stage_valid[1] !== 1'b0) begin errors++; $display("FAIL fs_tap: got %b expected 0", stage_valid[1]); end
        tick();
        stall = '0;
        flush = '0;
        settle();
        checks++; if (stage_valid !== 4'b1101) begin errors++; $display("FAIL fs_taps: got %b expected 1101", stage_valid); end
        checks++; if (flushed_cnt !== 4'd1) begin errors++; $display("FAIL fs_cnt: got %0d expected 1", flushed_cnt); end
        checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL fs_occupancy: got %0d expected 3", occupancy); end
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            settle();
            tick();
        end
        checks++;
        if (got.size() != 3 || got[0] !== 16'h0001 || got[1] !== 16'h0002 || got[2] !== 16'h0004) begin
            errors++; $display("FAIL fs_retire: got %0d items expected 0001,0002,0004", got.size());
        end
    endtask

    task automatic test_reset_mid();
        fill_four(49);
        settle();
        checks++; if (occupancy !== 3'd4 || retired_cnt !== 4'd3) begin errors++; $display("FAIL rm_before: got occ %0d ret %0d expected 4/3", occupancy, retired_cnt); end
        tick();
        reset = 1'b0;
        settle();
        tick();
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 16'h0055;
        settle();
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rm_occupancy: got %0d expected 0", occupancy); end
        checks++; if (retired_cnt !== 4'd0 || flushed_cnt !== 4'd0) begin errors++; $display("FAIL rm_counters: got %0d/%0d expected 0/0", retired_cnt, flushed_cnt); end
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rm_ports: got out_valid %b in_ready %b expected 0/1", out_valid, in_ready); end
        tick();
        in_valid = 1'b0;
        settle();
        checks++; if (stage_valid !== 4'b0001 || stage_data[0 +: W] !== 16'h0055) begin errors++; $display("FAIL rm_accept: got %b/%h expected 0001/0055", stage_valid, stage_data[0 +: W]); end
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] tag = 16'h0100;
        logic [S-1:0] exp_sv;
        int           exp_occ;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 299) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = tag;
            out_ready = ($urandom_range(0, 99) < 75);
            for (int k = 0; k < S; k++) begin
                stall[k] = ($urandom_range(0, 99) < 12);
                flush[k] = ($urandom_range(0, 99) < 5);
            end
            settle();
            exp_occ = 0;
            for (int k = 0; k < S; k++) begin
                exp_sv[k] = alive[k];
                if (m_v[k]) exp_occ++;
            end
            checks++; if (in_ready !== takes[0]) begin errors++; $display("FAIL rnd_in_ready: cycle %0d got %b expected %b", c, in_ready, takes[0]); end
            checks++; if (out_valid !== (alive[S-1] && !stall[S-1])) begin errors++; $display("FAIL rnd_out_valid: cycle %0d got %b", c, out_valid); end
            checks++; if (stage_valid !== exp_sv) begin errors++; $display("FAIL rnd_stage_valid: cycle %0d got %b expected %b", c, stage_valid, exp_sv); end
            checks++; if (occupancy !== 3'(exp_occ)) begin errors++; $display("FAIL rnd_occupancy: cycle %0d got %0d expected %0d", c, occupancy, exp_occ); end
            checks++; if (retired_cnt !== CW'(m_ret) || flushed_cnt !== CW'(m_fl)) begin errors++; $display("FAIL rnd_counters: cycle %0d got %0d/%0d expected %0d/%0d", c, retired_cnt, flushed_cnt, m_ret, m_fl); end
            for (int k = 0; k < S; k++) begin
                if (alive[k]) begin
                    checks++; if (stage_data[k*W +: W] !== m_d[k]) begin errors++; $display("FAIL rnd_stage_data: cycle %0d stage %0d got %h expected %h", c, k, stage_data[k*W +: W], m_d[k]); end
                end
            end
            if (out_valid && out_ready) begin
                checks++; if (sb.size() == 0 || out_data !== sb[0]) begin errors++; $display("FAIL rnd_order: cycle %0d got %h, scoreboard size %0d", c, out_data, sb.size()); end
            end
            if (reset && in_valid && in_ready) tag++;
            tick();
        end
        reset = 1'b1; in_valid = 1'b0; stall = '0; flush = '0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_stall_bubble();
        test_flush();
        test_flush_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised in-order pipeline register chain that replaces the hard-wired inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the LEGv8 pipeline with one generic block. Each stage carries a `WIDTH`-bit payload plus a valid bit. The block supports per-stage stall with automatic bubble insertion, per-stage flush for branch redirects, valid/ready backpressure at both ends, and occupancy/retire/flush counters for simulation and debug. It sits between the pipeline stage logic blocks (fetch, iDecode, iExecute, iMemory, writeback), which read taps from it.

## Interface
Parameters:
- `WIDTH`, default 64 (`WORD`): payload bits per stage.
- `STAGES`, default 4: number of register stages, minimum 1. Stage 0 is the youngest (IF/ID); stage `STAGES-1` is the oldest (output).
- `CNT_W`, default 32: width of the retire and flush counters.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  upstream payload valid.
- `in_data`  in  WIDTH  upstream payload.
- `in_ready`  out  1  stage 0 accepts this cycle.
- `stall`  in  STAGES  bit k holds stage k.
- `flush`  in  STAGES  bit k kills the content of stage k.
- `out_valid`  out  1  oldest stage presents a payload.
- `out_data`  out  WIDTH  payload of stage `STAGES-1`.
- `out_ready`  in  1  downstream accepts.
- `stage_valid`  out  STAGES  effective valid per stage (tap).
- `stage_data`  out  STAGES*WIDTH  payload taps; stage k occupies bits [k*WIDTH +: WIDTH].
- `occupancy`  out  $clog2(STAGES+1)  popcount of registered valid bits.
- `retired_cnt`  out  CNT_W  count of output transfers; saturating.
- `flushed_cnt`  out  CNT_W  count of valid entries killed by flush; saturating.

## Operation
- State per stage k: `v[k]`, `d[k]`.
- Effective valid: `ve[k] = v[k] & ~flush[k]`. Flushed content never moves.
- Move and accept, evaluated from oldest to youngest:
  - `move[S-1] = ve[S-1] & ~stall[S-1] & out_ready`.
  - `move[k] = ve[k] & ~stall[k] & accept[k+1]`.
  - `accept[k] = ~stall[k] & (~ve[k] | move[k])`.
- Next state when `accept[k]`:
  - k = 0: `v[0] <= in_valid`, `d[0] <= in_data`.
  - k > 0: `v[k] <= move[k-1]`, `d[k] <= d[k-1]`.
  - When the predecessor does not move, stage k receives a bubble (`v = 0`).
- Next state otherwise (stalled, or blocked with valid content): `v[k] <= ve[k]` and `d[k]` holds.
- Flush and stall on the same stage: flush wins, and `v[k]` clears.
- A stage is not flushed by `flush[k-1]`: a flushed predecessor leaves a bubble in stage k.
- `flush[0]` does not kill the `in_data` being accepted that cycle; upstream fetch owns its own redirect.
- Output ports:
  - `in_ready = accept[0]`.
  - `out_valid = ve[S-1] & ~stall[S-1]`.
  - `out_data = d[S-1]`.
  - `stage_valid = ve`.
  - Transfer occurs when `out_valid & out_ready`.
- `occupancy` counts registered `v`, not `ve`.
- Counters:
  - `retired_cnt` +1 per transfer.
  - `flushed_cnt` + popcount(`v & flush`) per cycle.
  - Both saturate at all-ones and never wrap.
- Payload bits are opaque; there is no arithmetic on data.

## Timing
- Reset (`reset == 0` at an edge): all `v` = 0, all `d` = 0, both counters = 0. At the following edge, `in_ready` = 1 and `out_valid` = 0.
- Reset mid-operation discards all in-flight entries. Discarded entries are not counted as flushed.
- Latency: a payload accepted at edge N presents on `out_valid` after edge N+STAGES-1, i.e. `STAGES` edges from `in_valid` being sampled to output register loaded, with no stall or backpressure.
- Throughput: one payload per cycle when `out_ready = 1` and there are no stalls.
- `in_ready` is combinational through the chain from `out_ready`, `stall` and `flush`; this is a ripple path of depth `STAGES`.
- Full pipe with `out_ready = 0`: all stages hold and `in_ready = 0`. With `out_ready = 1`, the full pipe advances every stage in the same cycle (no bubble).
- STAGES = 1: the block degenerates to a single register with flush/stall.

## Test plan
- Stream: STAGES=4, reset released, feed 0x1..0x8 back-to-back with `out_ready=1` -> first `out_valid` 4 edges after the first accept; outputs in order 0x1..0x8 on consecutive cycles; `retired_cnt=8`, `flushed_cnt=0`.
- Backpressure: `out_ready=0`, feed 0xA..0xF -> after 4 accepts `in_ready=0` and `occupancy=4`; raise `out_ready` -> 0xA..0xD drain, then 0xE, 0xF, with no duplicate or loss.
- Stall bubble: stream with `stall=4'b0010` for 2 cycles -> stage 2 receives 2 bubbles; stage 0 holds once valid and `in_ready=0`; data order preserved.
- Flush: full pipe holding 0x4 (s0)..0x1 (s3), `flush=4'b0011` for one cycle -> `stage_valid=4'b1100` next edge minus any moves; 0x2 and 0x1 still retire; `flushed_cnt=2`.
- Flush+stall: `stall[1]=flush[1]=1` on a valid stage 1 -> `v[1]=0` next edge; `flushed_cnt` +1.
- Reset mid-stream: full pipe, `reset=0` for one edge -> `occupancy=0`, counters 0, `out_valid=0`; the next `in_valid` is accepted immediately.
